// File: rtl/led_scan_scheduler.sv
// Row-scan sequencer for a double-buffered LED matrix: fetch, blank, PWM-drive each row,
// and swap display banks only at frame boundaries (or while idle) through a req/ack handshake.
module led_scan_scheduler #(
  parameter int ROWS         = 16,
  parameter int COLS         = 104,
  parameter int PWM_BITS     = 8,
  parameter int BLANK_CYCLES = 4,
  parameter int MEM_LAT      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] intensity,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic                active_bank,
  output logic                rd_en,
  output logic                rd_bank,
  output logic [3:0]          rd_row,
  input  logic [COLS-1:0]     rd_data,
  output logic                frame_start,
  output logic [COLS-1:0]     columns,
  output logic [ROWS-1:0]     rows
);

  localparam int BC_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BC_W-1:0]     r_blank_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_int_l;
  logic [3:0]          r_row;
  logic [COLS-1:0]     r_row_buf;
  logic                r_active_bank;
  logic                r_swap_ack;
  logic                r_swap_blk;
  logic [ROWS-1:0]     r_rows;
  logic [COLS-1:0]     r_columns;

  logic w_blank_last;
  logic w_mem_cap;
  logic w_pwm_last;
  logic w_row_last;
  logic w_rd_en;
  logic w_frame_start;
  logic w_lit;
  logic w_swap;

  assign w_blank_last = (r_blank_cnt == BC_W'(BLANK_CYCLES - 1));
  assign w_mem_cap    = (r_blank_cnt == BC_W'(MEM_LAT));
  assign w_pwm_last   = (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign w_row_last   = (r_row == 4'(ROWS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a row always runs its full DRIVE before enable is honoured
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: begin
        if (w_blank_last) w_state_nxt = ST_DRIVE;
        else              w_state_nxt = ST_BLANK;
      end
      ST_DRIVE: begin
        if (w_pwm_last) w_state_nxt = enable ? ST_BLANK : ST_IDLE;
        else            w_state_nxt = ST_DRIVE;
      end
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_BLANK;
        else        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  // Output decode: RAM strobe, PWM gate and swap point
  always_comb begin
    w_rd_en       = 1'b0;
    w_frame_start = 1'b0;
    w_lit         = 1'b0;
    w_swap        = 1'b0;
    case (r_state)
      ST_BLANK: begin
        w_rd_en       = ~rst & (r_blank_cnt == '0);
        w_frame_start = ~rst & (r_blank_cnt == '0) & (r_row == 4'd0);
      end
      ST_DRIVE: begin
        w_lit  = (r_pwm_cnt < r_int_l);
        w_swap = w_pwm_last & w_row_last & swap_req;
      end
      ST_IDLE: begin
        w_swap = swap_req & ~r_swap_blk;
      end
      default: begin
        w_lit = 1'b0;
      end
    endcase
  end

  // Scan counters, row fetch latch and brightness latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank_cnt <= '0;
      r_pwm_cnt   <= '0;
      r_int_l     <= '0;
      r_row       <= 4'd0;
      r_row_buf   <= '0;
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (w_blank_last) begin
            r_blank_cnt <= '0;
            r_int_l     <= intensity;
            r_pwm_cnt   <= '0;
          end else begin
            r_blank_cnt <= r_blank_cnt + BC_W'(1);
          end
          if (w_mem_cap) r_row_buf <= rd_data;
        end
        ST_DRIVE: begin
          r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
          if (w_pwm_last) r_row <= w_row_last ? 4'd0 : r_row + 4'd1;
        end
        default: begin
          r_blank_cnt <= '0;
        end
      endcase
    end
  end

  // Bank swap handshake; r_swap_blk stops a held request re-swapping every idle cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active_bank <= 1'b0;
      r_swap_ack    <= 1'b0;
      r_swap_blk    <= 1'b0;
    end else begin
      if (w_swap) r_active_bank <= ~r_active_bank;
      r_swap_ack <= w_swap;
      r_swap_blk <= w_swap | (r_swap_blk & swap_req);
    end
  end

  // Registered active-low latch drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows    <= '1;
      r_columns <= '1;
    end else begin
      r_rows    <= w_lit ? ~(ROWS'(1) << r_row) : '1;
      r_columns <= w_lit ? ~r_row_buf : '1;
    end
  end

  assign swap_ack    = r_swap_ack;
  assign active_bank = r_active_bank;
  assign rd_en       = w_rd_en;
  assign rd_bank     = r_active_bank;
  assign rd_row      = r_row;
  assign frame_start = w_frame_start;
  assign columns     = r_columns;
  assign rows        = r_rows;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Directed bench for led_scan_scheduler: scan timing, PWM, blanking, bank swap, enable and reset.
module tb_led_scan_scheduler;
  localparam int ROWS = 16;
  localparam int COLS = 104;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [7:0]      intensity;
  logic            swap_req;
  logic            swap_ack;
  logic            active_bank;
  logic            rd_en;
  logic            rd_bank;
  logic [3:0]      rd_row;
  logic [COLS-1:0] rd_data = '0;
  logic            frame_start;
  logic [COLS-1:0] columns;
  logic [ROWS-1:0] rows;

  logic [COLS-1:0] mem [2][ROWS];
  logic [COLS-1:0] ones_c;
  int checks   = 0;
  int failures = 0;
  int g        = 0;

  led_scan_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .intensity(intensity),
    .swap_req(swap_req), .swap_ack(swap_ack), .active_bank(active_bank),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row), .rd_data(rd_data),
    .frame_start(frame_start), .columns(columns), .rows(rows)
  );

  always #5 clk = ~clk;

  // one-cycle-latency pixel RAM
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_bank][rd_row];

  task automatic step();
    @(posedge clk);
    #2;
    g = g + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; intensity = 8'd255; swap_req = 1'b0;
    repeat (3) step();
    checks++; if (rows !== 16'hFFFF) begin failures++; $display("FAIL reset_rows got=%h exp=ffff", rows); end
    checks++; if (columns !== ones_c) begin failures++; $display("FAIL reset_columns got=%h exp=all-1", columns); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (swap_ack !== 1'b0 || active_bank !== 1'b0 || rd_bank !== 1'b0 || rd_row !== 4'd0) begin
      failures++; $display("FAIL reset_misc got=%b%b%b%h exp=0000", swap_ack, active_bank, rd_bank, rd_row);
    end
    rst = 1'b0;
    #1;
    g = 0;
  endtask

  task automatic test_scan_timing();
    int rd_err = 0, fs_err = 0, row_err = 0, col_err = 0, rd_cnt = 0, fs_cnt = 0;
    int r, o;
    logic [15:0] exp_rows;
    logic [COLS-1:0] exp_cols;
    for (int c = 0; c <= 4160; c++) begin
      r = (g / 260) % 16;
      o = g % 260;
      if (rd_en !== (o == 0)) rd_err++;
      if (rd_en === 1'b1) begin
        rd_cnt++;
        if (rd_row !== 4'(r) || rd_bank !== 1'b0) rd_err++;
      end
      if (frame_start !== ((g % 4160) == 0)) fs_err++;
      if (frame_start === 1'b1) fs_cnt++;
      exp_rows = (o >= 5) ? ~(16'd1 << r) : 16'hFFFF;
      exp_cols = (o >= 5) ? ~mem[0][r] : ones_c;
      if (rows !== exp_rows) row_err++;
      if (columns !== exp_cols) col_err++;
      if (c < 4160) step();
    end
    checks++; if (rd_err !== 0) begin failures++; $display("FAIL t1_rd_en_timing got=%0d bad cycles exp=0", rd_err); end
    checks++; if (rd_cnt !== 17) begin failures++; $display("FAIL t1_rd_en_count got=%0d exp=17", rd_cnt); end
    checks++; if (fs_err !== 0 || fs_cnt !== 2) begin failures++; $display("FAIL t1_frame_start got=%0d err %0d pulses exp=0 err 2 pulses", fs_err, fs_cnt); end
    checks++; if (row_err !== 0) begin failures++; $display("FAIL t1_rows_walk got=%0d bad cycles exp=0", row_err); end
    checks++; if (col_err !== 0) begin failures++; $display("FAIL t1_columns got=%0d bad cycles exp=0", col_err); end
  endtask

  task automatic test_pwm_intensity();
    int col0_low = 0, oth_err = 0, lit0 = 0, lit1 = 0;
    intensity = 8'd128;
    for (int c = 0; c < 520; c++) begin
      if (c < 260) begin
        if (columns[0] === 1'b0) col0_low++;
        if (columns[COLS-1:1] !== ones_c[COLS-1:1]) oth_err++;
        if (rows === 16'hFFFE) lit0++;
        else if (rows !== 16'hFFFF) oth_err++;
      end else begin
        if (rows === 16'hFFFD) lit1++;
        else if (rows !== 16'hFFFF) oth_err++;
      end
      if (c == 100) intensity = 8'd64;
      if (c == 460) intensity = 8'd0;
      step();
    end
    checks++; if (col0_low !== 128) begin failures++; $display("FAIL t2_col0_low got=%0d exp=128", col0_low); end
    checks++; if (lit0 !== 128) begin failures++; $display("FAIL t2_row0_lit got=%0d exp=128", lit0); end
    checks++; if (lit1 !== 64) begin failures++; $display("FAIL t2_row1_lit_after_change got=%0d exp=64", lit1); end
    checks++; if (oth_err !== 0) begin failures++; $display("FAIL t2_other_outputs got=%0d bad cycles exp=0", oth_err); end
  endtask

  task automatic test_dark();
    int dark_err = 0, rd_cnt = 0;
    for (int c = 0; c < 4160; c++) begin
      if (rows !== 16'hFFFF || columns !== ones_c) dark_err++;
      if (rd_en === 1'b1) rd_cnt++;
      step();
    end
    checks++; if (dark_err !== 0) begin failures++; $display("FAIL t3_dark_frame got=%0d lit cycles exp=0", dark_err); end
    checks++; if (rd_cnt !== 16) begin failures++; $display("FAIL t3_fetches got=%0d exp=16", rd_cnt); end
  endtask

  task automatic test_swap_frame();
    int ack_cnt = 0, ack_g = -1, bank_err = 0;
    logic ack_ok = 1'b0;
    logic [COLS-1:0] col_b1 = '0;
    intensity = 8'd255;
    swap_req  = 1'b1;
    for (int c = 0; c <= 7800; c++) begin
      if (swap_ack === 1'b1) begin
        ack_cnt++;
        ack_g  = g;
        ack_ok = (active_bank === 1'b1) && (rd_bank === 1'b1) && (rd_en === 1'b1) && (frame_start === 1'b1);
        swap_req = 1'b0;
      end
      if (g < 12480 && active_bank !== 1'b0) bank_err++;
      if (g >= 12480 && active_bank !== 1'b1) bank_err++;
      if (g == 12490) col_b1 = columns;
      if (c < 7800) step();
    end
    checks++; if (ack_cnt !== 1) begin failures++; $display("FAIL t4_ack_count got=%0d exp=1", ack_cnt); end
    checks++; if (ack_g !== 12480) begin failures++; $display("FAIL t4_ack_cycle got=%0d exp=12480", ack_g); end
    checks++; if (ack_ok !== 1'b1) begin failures++; $display("FAIL t4_new_bank_fetch got=%b exp=1", ack_ok); end
    checks++; if (bank_err !== 0) begin failures++; $display("FAIL t4_bank_stable got=%0d bad cycles exp=0", bank_err); end
    checks++; if (col_b1 !== ~mem[1][0]) begin failures++; $display("FAIL t4_bank1_pixels got=%h exp=%h", col_b1, ~mem[1][0]); end
  endtask

  task automatic test_enable_idle();
    int lit_err = 0, idle_err = 0;
    while (g < 17954) step();
    enable = 1'b0;
    while (g < 18200) begin
      if (rows !== 16'hFFDF) lit_err++;
      step();
    end
    repeat (10) begin
      if (rd_en !== 1'b0 || rows !== 16'hFFFF || columns !== ones_c || swap_ack !== 1'b0) idle_err++;
      step();
    end
    checks++; if (lit_err !== 0) begin failures++; $display("FAIL t5_row5_completes got=%0d bad cycles exp=0", lit_err); end
    checks++; if (idle_err !== 0) begin failures++; $display("FAIL t5_idle_blank got=%0d bad cycles exp=0", idle_err); end
    swap_req = 1'b1;
    step();
    checks++; if (swap_ack !== 1'b1 || active_bank !== 1'b0) begin failures++; $display("FAIL t5_idle_swap1 got=ack %b bank %b exp=ack 1 bank 0", swap_ack, active_bank); end
    swap_req = 1'b0;
    step();
    checks++; if (swap_ack !== 1'b0) begin failures++; $display("FAIL t5_ack_pulse_width got=%b exp=0", swap_ack); end
    step();
    swap_req = 1'b1;
    step();
    checks++; if (swap_ack !== 1'b1 || active_bank !== 1'b1) begin failures++; $display("FAIL t5_idle_swap2 got=ack %b bank %b exp=ack 1 bank 1", swap_ack, active_bank); end
    swap_req = 1'b0;
    step();
    checks++; if (swap_ack !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL t5_still_idle got=ack %b rd_en %b exp=0 0", swap_ack, rd_en); end
    enable = 1'b1;
    step();
    checks++; if (rd_en !== 1'b1 || rd_row !== 4'd6 || rd_bank !== 1'b1 || frame_start !== 1'b0) begin
      failures++; $display("FAIL t5_resume_row got=rd_en %b row %0d bank %b fs %b exp=1 6 1 0", rd_en, rd_row, rd_bank, frame_start);
    end
  endtask

  task automatic test_reset_midrun();
    int ack_seen = 0;
    while (g < 19036) step();
    swap_req = 1'b1;
    while (g < 19046) begin
      step();
      if (swap_ack === 1'b1) ack_seen++;
    end
    checks++; if (rows !== 16'hFDFF) begin failures++; $display("FAIL t6_row9_lit got=%h exp=fdff", rows); end
    rst = 1'b1;
    step();
    if (swap_ack === 1'b1) ack_seen++;
    checks++; if (rows !== 16'hFFFF || columns !== ones_c) begin failures++; $display("FAIL t6_blank_after_rst got=%h exp=ffff", rows); end
    checks++; if (active_bank !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL t6_state_after_rst got=bank %b rd_en %b exp=0 0", active_bank, rd_en); end
    checks++; if (ack_seen !== 0) begin failures++; $display("FAIL t6_no_ack got=%0d exp=0", ack_seen); end
    rst = 1'b0;
    swap_req = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b1 || frame_start !== 1'b1 || rd_row !== 4'd0 || rd_bank !== 1'b0) begin
      failures++; $display("FAIL t6_restart got=rd_en %b fs %b row %0d bank %b exp=1 1 0 0", rd_en, frame_start, rd_row, rd_bank);
    end
    repeat (5) step();
    checks++; if (rows !== 16'hFFFE || swap_ack !== 1'b0) begin failures++; $display("FAIL t6_row0_lit got=%h ack %b exp=fffe ack 0", rows, swap_ack); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=still-running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ones_c = '1;
    for (int r = 0; r < ROWS; r++) begin
      mem[0][r] = {{(COLS-1){1'b0}}, 1'b1} << (r * 6);
      mem[1][r] = ~({{(COLS-1){1'b0}}, 1'b1} << r);
    end
    test_reset();
    test_scan_timing();
    test_pwm_intensity();
    test_dark();
    test_swap_frame();
    test_enable_idle();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
